// File: rtl/regfile_write_queue.sv
// Write-back FIFO feeding the register-file write port; drops writes to r0.
// Optional read bypass of pending entries is enabled by defining REGFILE_WQ_BYPASS_EN.
module regfile_write_queue #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_WIDTH-1:0]    in_addr,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     wr_stall,
  output logic                     wr_enable,
  output logic [ADDR_WIDTH-1:0]    wr_addr,
  output logic [WIDTH-1:0]         wr_data,
  input  logic [ADDR_WIDTH-1:0]    rd_addr,
  output logic                     rd_hit,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] mem_addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr_d [DEPTH];
  logic [WIDTH-1:0]      mem_data_q [DEPTH];
  logic [WIDTH-1:0]      mem_data_d [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  store_s;
  logic                  deq_s;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign wr_enable = (count_q != {CNT_W{1'b0}}) & ~wr_stall;
  assign wr_addr   = mem_addr_q[head_q];
  assign wr_data   = mem_data_q[head_q];
  assign count     = count_q;

  // Writes to r0 complete the handshake but never occupy a slot.
  assign store_s = in_valid & in_ready & (in_addr != {ADDR_WIDTH{1'b0}});
  assign deq_s   = wr_enable;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (store_s) begin
      mem_addr_d[tail_q] = in_addr;
      mem_data_d[tail_q] = in_data;
      tail_d             = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end
    if (deq_s) begin
      head_d = head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end
    case ({store_s, deq_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset taking priority over enq/deq.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr_q[i] <= {ADDR_WIDTH{1'b0}};
        mem_data_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

`ifdef REGFILE_WQ_BYPASS_EN
  logic [PTR_W-1:0] byp_idx_s;

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    rd_hit    = 1'b0;
    rd_data   = {WIDTH{1'b0}};
    byp_idx_s = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      byp_idx_s = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (rd_addr != {ADDR_WIDTH{1'b0}}) &&
          (mem_addr_q[byp_idx_s] == rd_addr)) begin
        rd_hit  = 1'b1;
        rd_data = mem_data_q[byp_idx_s];
      end else begin
        rd_hit  = rd_hit;
        rd_data = rd_data;
      end
    end
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_hit         = 1'b0;
  assign rd_data        = {WIDTH{1'b0}};
`endif

endmodule
